// File: rtl/ws2812b_rx.sv
// WS2812B single-wire receiver: measures high widths to recover GRB pixel words
// and detects the long low that latches a frame.
module ws2812b_rx #(
  parameter int BIT_THRESH   = 8,
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 20,
  parameter int RESET_CYCLES = 600,
  parameter int NUM_PIXELS   = 64,
  parameter int ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic [23:0]       o_pixel,
  output logic              o_pixel_valid,
  output logic [ADDR_W-1:0] o_pixel_index,
  output logic              o_frame_done,
  output logic [ADDR_W:0]   o_frame_count,
  output logic              o_error
);

  localparam int WCW = $clog2(RESET_CYCLES + 1);
  localparam logic [WCW-1:0]  W_RESET  = WCW'(RESET_CYCLES);
  localparam logic [WCW-1:0]  W_LATCH  = WCW'(RESET_CYCLES - 1);
  localparam logic [WCW-1:0]  W_THRESH = WCW'(BIT_THRESH);
  localparam logic [WCW-1:0]  W_MIN    = WCW'(MIN_HIGH);
  localparam logic [WCW-1:0]  W_MAX    = WCW'(MAX_HIGH);
  localparam logic [ADDR_W:0] PIX_MAX  = (ADDR_W + 1)'(NUM_PIXELS);

  typedef enum logic [1:0] {
    WAIT_LATCH,
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t         state;
  logic           din_meta;
  logic           din_s;
  logic           din_d;
  logic           rise;
  logic           fall;
  logic           line_quiet;
  logic           bit_val;
  logic [WCW-1:0] width;
  logic [22:0]    shift;
  logic [4:0]     bit_cnt;
  logic [ADDR_W:0] pix_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_meta <= 1'b0;
      din_s    <= 1'b0;
      din_d    <= 1'b0;
    end else begin
      din_meta <= din;
      din_s    <= din_meta;
      din_d    <= din_s;
    end
  end

  assign rise       = din_s & ~din_d;
  assign fall       = ~din_s & din_d;
  assign line_quiet = ~din_s & ~din_d;
  assign bit_val    = (width >= W_THRESH);

  // The edge cycle is already the first cycle of the new level, so restart at 1;
  // at a fall, width then equals the number of high cycles just seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width <= '0;
    end else if (rise || fall) begin
      width <= WCW'(1);
    end else if (width != W_RESET) begin
      width <= width + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_LATCH;
      shift         <= '0;
      bit_cnt       <= '0;
      pix_cnt       <= '0;
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
      o_pixel_index <= '0;
      o_frame_done  <= 1'b0;
      o_frame_count <= '0;
      o_error       <= 1'b0;
    end else begin
      o_pixel_valid <= 1'b0;
      o_frame_done  <= 1'b0;
      o_error       <= 1'b0;
      case (state)
        WAIT_LATCH: begin
          if (line_quiet && width >= W_LATCH) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (rise) begin
            state <= HIGH;
          end
        end
        HIGH: begin
          if (width >= W_MAX || (fall && width < W_MIN)) begin
            o_error <= 1'b1;
            bit_cnt <= '0;
            pix_cnt <= '0;
            state   <= WAIT_LATCH;
          end else if (fall) begin
            shift <= {shift[21:0], bit_val};
            state <= LOW;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              // A pixel past the end of the frame is flagged and dropped, but the stream is still decoded.
              if (pix_cnt == PIX_MAX) begin
                o_error <= 1'b1;
              end else begin
                o_pixel       <= {shift, bit_val};
                o_pixel_index <= pix_cnt[ADDR_W-1:0];
                o_pixel_valid <= 1'b1;
                pix_cnt       <= pix_cnt + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
          end else if (width >= W_LATCH) begin
            o_frame_done  <= 1'b1;
            o_frame_count <= pix_cnt;
            o_error       <= (bit_cnt != 5'd0);
            bit_cnt       <= '0;
            pix_cnt       <= '0;
            state         <= IDLE;
          end
        end
        default: state <= WAIT_LATCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx: drives WS2812B waveforms and checks decoded pixels
// and frame latches against a scoreboard of expected results.
`timescale 1ns/1ps
module tb_ws2812b_rx;

  logic        clk;
  logic        rst_n;
  logic        din;
  logic [23:0] o_pixel;
  logic        o_pixel_valid;
  logic [5:0]  o_pixel_index;
  logic        o_frame_done;
  logic [6:0]  o_frame_count;
  logic        o_error;

  typedef struct {
    logic [23:0] word;
    logic [5:0]  idx;
  } pix_t;

  typedef struct {
    logic [6:0] count;
    logic       err;
  } frm_t;

  pix_t pq[$];
  frm_t fq[$];
  pix_t pe;
  frm_t fe;

  int n_assert = 0;
  int n_fail = 0;
  int err_total = 0;
  int err_before;
  int cyc = 0;
  int last_fall_cyc = 0;

  ws2812b_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .din           (din),
    .o_pixel       (o_pixel),
    .o_pixel_valid (o_pixel_valid),
    .o_pixel_index (o_pixel_index),
    .o_frame_done  (o_frame_done),
    .o_frame_count (o_frame_count),
    .o_error       (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds the line at level for n cycles.
  task automatic applyStimulus(input logic level, input int n);
    if (din && !level) last_fall_cyc = cyc;
    din = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit_w(input int high, input int low);
    applyStimulus(1'b1, high);
    applyStimulus(1'b0, low);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_bit_w(10, 5);
    else   send_bit_w(5, 10);
  endtask

  task automatic send_pixel(input logic [23:0] word, input bit expect_valid, input int idx);
    pix_t p;
    if (expect_valid) begin
      p.word = word;
      p.idx  = idx[5:0];
      pq.push_back(p);
    end
    for (int i = 23; i >= 0; i--) send_bit(word[i]);
  endtask

  task automatic expect_frame(input int count, input logic err);
    frm_t f;
    f.count = count[6:0];
    f.err   = err;
    fq.push_back(f);
  endtask

  always @(negedge clk) begin
    if (o_pixel_valid) begin
      if (pq.size() == 0) begin
        checkOutput("spurious_valid", 32'(o_pixel_valid), 32'd0);
      end else begin
        pe = pq.pop_front();
        checkOutput("pixel_word", 32'(o_pixel), 32'(pe.word));
        checkOutput("pixel_index", 32'(o_pixel_index), 32'(pe.idx));
        checkOutput("pixel_latency", 32'(cyc - last_fall_cyc), 32'd3);
      end
    end
    if (o_frame_done) begin
      checkOutput("done_with_valid", 32'(o_pixel_valid), 32'd0);
      if (fq.size() == 0) begin
        checkOutput("spurious_frame_done", 32'(o_frame_done), 32'd0);
      end else begin
        fe = fq.pop_front();
        checkOutput("frame_count", 32'(o_frame_count), 32'(fe.count));
        checkOutput("frame_error", 32'(o_error), 32'(fe.err));
      end
    end
    if (o_error) err_total++;
  end

  initial begin
    logic [23:0] word6;
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pixel", 32'(o_pixel), 32'd0);
    checkOutput("rst_valid", 32'(o_pixel_valid), 32'd0);
    checkOutput("rst_index", 32'(o_pixel_index), 32'd0);
    checkOutput("rst_done", 32'(o_frame_done), 32'd0);
    checkOutput("rst_count", 32'(o_frame_count), 32'd0);
    checkOutput("rst_error", 32'(o_error), 32'd0);
    rst_n = 1'b1;

    $display("[TB] step 1: single pixel after initial latch");
    err_before = err_total;
    applyStimulus(1'b0, 620);
    send_pixel(24'hA5C33C, 1'b1, 0);
    expect_frame(1, 1'b0);
    applyStimulus(1'b0, 620);
    checkOutput("t1_pixels_drained", 32'(pq.size()), 32'd0);
    checkOutput("t1_frames_drained", 32'(fq.size()), 32'd0);
    checkOutput("t1_held_pixel", 32'(o_pixel), 32'hA5C33C);
    checkOutput("t1_errors", 32'(err_total - err_before), 32'd0);

    $display("[TB] step 2: three-pixel frame");
    err_before = err_total;
    send_pixel(24'h000001, 1'b1, 0);
    send_pixel(24'hFF0000, 1'b1, 1);
    send_pixel(24'h00FF00, 1'b1, 2);
    expect_frame(3, 1'b0);
    applyStimulus(1'b0, 620);
    checkOutput("t2_pixels_drained", 32'(pq.size()), 32'd0);
    checkOutput("t2_frames_drained", 32'(fq.size()), 32'd0);
    checkOutput("t2_errors", 32'(err_total - err_before), 32'd0);

    $display("[TB] step 3: partial pixel at latch");
    err_before = err_total;
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    expect_frame(0, 1'b1);
    applyStimulus(1'b0, 620);
    checkOutput("t3_frames_drained", 32'(fq.size()), 32'd0);
    checkOutput("t3_errors", 32'(err_total - err_before), 32'd1);
    checkOutput("t3_count_held", 32'(o_frame_count), 32'd0);

    $display("[TB] step 4: glitch, then stuck-high");
    err_before = err_total;
    for (int i = 0; i < 12; i++) send_bit(i[1]);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 620);
    checkOutput("t4_glitch_errors", 32'(err_total - err_before), 32'd1);
    err_before = err_total;
    send_pixel(24'h123456, 1'b1, 0);
    applyStimulus(1'b1, 25);
    applyStimulus(1'b0, 620);
    checkOutput("t4_stuck_errors", 32'(err_total - err_before), 32'd1);
    err_before = err_total;
    send_pixel(24'h0F0F0F, 1'b1, 0);
    expect_frame(1, 1'b0);
    applyStimulus(1'b0, 620);
    checkOutput("t4_pixels_drained", 32'(pq.size()), 32'd0);
    checkOutput("t4_frames_drained", 32'(fq.size()), 32'd0);
    checkOutput("t4_clean_errors", 32'(err_total - err_before), 32'd0);

    $display("[TB] step 5: 65 pixels into a 64-pixel frame");
    err_before = err_total;
    for (int i = 0; i < 65; i++) begin
      send_pixel({i[7:0], ~i[7:0], i[7:0] ^ 8'h5A}, (i < 64), i);
    end
    checkOutput("t5_overflow_errors", 32'(err_total - err_before), 32'd1);
    checkOutput("t5_last_pixel_held", 32'(o_pixel), {8'd0, 8'd63, ~8'd63, 8'd63 ^ 8'h5A});
    expect_frame(64, 1'b0);
    applyStimulus(1'b0, 620);
    checkOutput("t5_pixels_drained", 32'(pq.size()), 32'd0);
    checkOutput("t5_frames_drained", 32'(fq.size()), 32'd0);

    $display("[TB] step 6: threshold widths and mid-pixel reset");
    err_before = err_total;
    word6 = 24'hF0A55A;
    pe.word = word6;
    pe.idx  = 6'd0;
    pq.push_back(pe);
    for (int i = 23; i >= 0; i--) begin
      if (word6[i]) send_bit_w(8, 7);
      else          send_bit_w(i[0] ? 7 : 2, 7);
    end
    expect_frame(1, 1'b0);
    applyStimulus(1'b0, 620);
    checkOutput("t6_pixels_drained", 32'(pq.size()), 32'd0);
    checkOutput("t6_frames_drained", 32'(fq.size()), 32'd0);
    checkOutput("t6_errors", 32'(err_total - err_before), 32'd0);

    for (int i = 0; i < 10; i++) send_bit(i[0]);
    rst_n = 1'b0;
    din   = 1'b0;
    #1;
    checkOutput("t6_rst_pixel", 32'(o_pixel), 32'd0);
    checkOutput("t6_rst_count", 32'(o_frame_count), 32'd0);
    checkOutput("t6_rst_valid", 32'(o_pixel_valid), 32'd0);
    checkOutput("t6_rst_error", 32'(o_error), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    err_before = err_total;
    send_pixel(24'h555555, 1'b0, 0);
    applyStimulus(1'b0, 620);
    send_pixel(24'hABCDEF, 1'b1, 0);
    expect_frame(1, 1'b0);
    applyStimulus(1'b0, 620);
    checkOutput("t6_post_rst_pixel", 32'(o_pixel), 32'hABCDEF);
    checkOutput("t6_post_rst_errors", 32'(err_total - err_before), 32'd0);

    checkOutput("final_pixels_drained", 32'(pq.size()), 32'd0);
    checkOutput("final_frames_drained", 32'(fq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
